// File: rtl/bit_serializer.sv
// bit_serializer: one-word holding register feeding a shift register that emits one bit per tick on sout.
// BIT_SERIALIZER_PARITY_EN appends an even-parity bit to every frame (frame length WIDTH+1).
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             _rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             tick,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             frame_done
);

`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif
   localparam int            CW   = $clog2(FLEN);
   localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] hold_data, hold_data_nxt;
   logic             hold_valid, hold_valid_nxt;
   logic [WIDTH-1:0] sh, sh_nxt, sh_shifted;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             frame_done_nxt;
   logic             accept;
   logic             load;
   logic             data_bit;

   // Holding register: accepts only when empty, so din_ready is purely registered.
   assign accept         = din_valid & ~hold_valid;
   assign hold_valid_nxt = accept | (hold_valid & ~load);
   assign hold_data_nxt  = accept ? din : hold_data;

   assign sh_shifted = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
   assign data_bit   = MSB_FIRST ? sh[WIDTH-1] : sh[0];

   always_comb begin
      state_nxt      = state;
      sh_nxt         = sh;
      cnt_nxt        = cnt;
      frame_done_nxt = 1'b0;
      load           = 1'b0;
      case (state)
         IDLE: begin
            if (hold_valid) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (cnt != LAST) begin
                  sh_nxt  = sh_shifted;
                  cnt_nxt = cnt + 1'b1;
               end else begin
                  frame_done_nxt = 1'b1;
                  // Reloading on the last-bit edge keeps consecutive frames gap-free.
                  if (hold_valid) begin
                     load = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (load) begin
         sh_nxt  = hold_data;
         cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         state      <= IDLE;
         hold_data  <= '0;
         hold_valid <= 1'b0;
         sh         <= '0;
         cnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold_data  <= hold_data_nxt;
         hold_valid <= hold_valid_nxt;
         sh         <= sh_nxt;
         cnt        <= cnt_nxt;
         frame_done <= frame_done_nxt;
      end
   end

`ifdef BIT_SERIALIZER_PARITY_EN
   logic parity;

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         parity <= 1'b0;
      end else if (load) begin
         parity <= ^hold_data;
      end
   end

   // The final slot of each frame carries the parity bit instead of data.
   assign sout = (state == SHIFT) & ((cnt == CW'(WIDTH)) ? parity : data_bit);
`else
   assign sout = (state == SHIFT) & data_bit;
`endif

   assign din_ready  = ~hold_valid;
   assign sout_valid = (state == SHIFT);
   assign busy       = (state == SHIFT) | hold_valid;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance, WIDTH = 8.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int          FL      = 9;
   localparam logic [17:0] EXP_B2B = {8'hFF, 1'b0, 8'h00, 1'b0};
`else
   localparam int          FL      = 8;
   localparam logic [17:0] EXP_B2B = 18'h0FF00;
`endif

   logic       clk = 1'b0;
   logic       _rst;
   logic [7:0] din_a, din_b;
   logic       din_valid_a, din_valid_b;
   logic       din_ready_a, din_ready_b;
   logic       tick_a, tick_b;
   logic       sout_a, sout_b;
   logic       sout_valid_a, sout_valid_b;
   logic       busy_a, busy_b;
   logic       frame_done_a, frame_done_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), ._rst(_rst), .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
      .tick(tick_a), .sout(sout_a), .sout_valid(sout_valid_a), .busy(busy_a), .frame_done(frame_done_a)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), ._rst(_rst), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
      .tick(tick_b), .sout(sout_b), .sout_valid(sout_valid_b), .busy(busy_b), .frame_done(frame_done_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // e[i] is the i-th bit expected on sout; e[8] is the parity bit (only used when enabled).
   task automatic run_frame(input logic [7:0] w, input logic [8:0] e, input string tag);
      check({tag, "_ready_idle"}, din_ready_a, 1);
      din_a       = w;
      din_valid_a = 1'b1;
      step();
      din_valid_a = 1'b0;
      check({tag, "_ready_held"}, din_ready_a, 0);
      check({tag, "_busy_held"}, busy_a, 1);
      check({tag, "_vld_early"}, sout_valid_a, 0);
      step();
      for (int i = 0; i < FL; i++) begin
         check({tag, "_bit"}, sout_a, e[i]);
         check({tag, "_vld"}, sout_valid_a, 1);
         check({tag, "_done_mid"}, frame_done_a, 0);
         step();
      end
      check({tag, "_done"}, frame_done_a, 1);
      check({tag, "_vld_end"}, sout_valid_a, 0);
      check({tag, "_sout_end"}, sout_a, 0);
      check({tag, "_busy_end"}, busy_a, 0);
      step();
      check({tag, "_done_clr"}, frame_done_a, 0);
   endtask

   initial begin
      int          nacc;
      int          vcount;
      int          gaps;
      int          ndone;
      int          bad;
      bit          ended;
      bit          acc;
      logic [17:0] got;

      _rst        = 1'b0;
      din_a       = '0;
      din_b       = '0;
      din_valid_a = 1'b0;
      din_valid_b = 1'b0;
      tick_a      = 1'b1;
      tick_b      = 1'b0;
      step();
      check("rst_ready", din_ready_a, 1);
      check("rst_sout", sout_a, 0);
      check("rst_vld", sout_valid_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", frame_done_a, 0);
      check("rst_ready_b", din_ready_b, 1);
      step();
      _rst = 1'b1;
      step();

      // Single frame, MSB first: B6 -> 1,0,1,1,0,1,1,0 (+ parity 1)
      run_frame(8'hB6, 9'b1_0110_1101, "msb_b6");

      // Back-to-back FF then 00 with din_valid held high
      nacc = 0; vcount = 0; gaps = 0; ndone = 0; ended = 1'b0; got = '0;
      din_a       = 8'hFF;
      din_valid_a = 1'b1;
      for (int c = 0; c < 60; c++) begin
         acc = din_valid_a && din_ready_a;
         if (frame_done_a) ndone++;
         if (sout_valid_a) begin
            if (vcount == FL - 1) check("b2b_ready_before_reload", din_ready_a, 0);
            if (vcount == FL) check("b2b_ready_after_reload", din_ready_a, 1);
            if (ended) gaps++;
            got = {got[16:0], sout_a};
            vcount++;
         end else if (vcount > 0) begin
            ended = 1'b1;
         end
         if (acc && nacc == 1) check("b2b_accept_while_shifting", sout_valid_a, 1);
         step();
         if (acc) begin
            nacc++;
            if (nacc == 1) din_a = 8'h00;
            else din_valid_a = 1'b0;
         end
      end
      check("b2b_vld_cycles", vcount, 2 * FL);
      check("b2b_gaps", gaps, 0);
      check("b2b_bits", got, EXP_B2B);
      check("b2b_done_pulses", ndone, 2);
      check("b2b_accepts", nacc, 2);

      // LSB first, tick every 3rd cycle: 01 -> 1 for 3 cycles then 0s (+ parity 1)
      din_b       = 8'h01;
      din_valid_b = 1'b1;
      step();
      din_valid_b = 1'b0;
      step();
      for (int v = 0; v < 3 * FL; v++) begin
         logic [8:0] e3;
         e3 = 9'b1_0000_0001;
         check("lsb_slow_bit", sout_b, e3[v / 3]);
         check("lsb_slow_vld", sout_valid_b, 1);
         tick_b = (v % 3 == 2);
         step();
      end
      tick_b = 1'b0;
      check("lsb_slow_done", frame_done_b, 1);
      check("lsb_slow_vld_end", sout_valid_b, 0);
      check("lsb_slow_busy_end", busy_b, 0);

      // Reset mid-frame: A5 shifting, 3C in the holding register
      din_a       = 8'hA5;
      din_valid_a = 1'b1;
      step();
      din_a = 8'h3C;
      step();
      step();
      din_valid_a = 1'b0;
      step();
      step();
      step();
      check("mid_vld", sout_valid_a, 1);
      check("mid_ready_full", din_ready_a, 0);
      check("mid_busy", busy_a, 1);
      _rst = 1'b0;
      #1;
      check("arst_sout", sout_a, 0);
      check("arst_vld", sout_valid_a, 0);
      check("arst_busy", busy_a, 0);
      check("arst_ready", din_ready_a, 1);
      step();
      _rst = 1'b1;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (sout_valid_a || busy_a || !din_ready_a || frame_done_a) bad++;
      end
      check("post_rst_quiet", bad, 0);
      run_frame(8'h81, 9'b0_1000_0001, "post_rst_81");

      // Parity vectors (plain frames when parity is disabled)
      run_frame(8'h07, 9'b1_1110_0000, "par_07");
      run_frame(8'h03, 9'b0_1100_0000, "par_03");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
